mult32u_mac_ctrl: RTL and testbench
===================================

# mult32u_mac_ctrl

Operand-issue and product-accumulate controller for the registered 32x32 unsigned multiplier wrapper `mult32u_booth4_koggestone_wrapper`. It accepts a valid/ready stream of operand pairs grouped by `in_last` and drives the wrapper's operand inputs. It tracks the wrapper's fixed 2-cycle pipeline, sums the returned 64-bit products into a wide accumulator, and presents one dot-product result per group on a valid/ready output.

## Interface
- `ACC_W`, default 80: accumulator/result width; must be >= 64.
- `LAT`, default 2: multiplier latency in cycles, from operands driven to `mul_p` valid.
- `CNT_W`, default 16: width of the beat counter.

- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block accepts the pair this cycle.
- `in_last`  in  1  final pair of the current group.
- `in_a`  in  32  multiplicand.
- `in_b`  in  32  multiplier.
- `mul_a`  out  32  to wrapper `multiplicand`.
- `mul_b`  out  32  to wrapper `multiplier`.
- `mul_p`  in  64  from wrapper `product`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_acc`  out  ACC_W  sum of the group's products.
- `out_count`  out  CNT_W  number of beats in the group, saturating.
- `out_ovf`  out  1  accumulator carry-out or count saturation occurred in the group.

## Operation
- State machine with three states: ACCUM (reset state), DRAIN, HOLD.
- `in_ready` = (state == ACCUM). Accept = `in_valid && in_ready`.
- Operand drive:
  - On accept, `mul_a`/`mul_b` = `in_a`/`in_b`, combinationally.
  - Otherwise both are 0, to suppress toggling.
- Pipeline tracking:
  - `vpipe[LAT-1:0]` and `lpipe[LAT-1:0]` shift each cycle.
  - Stage 0 loads accept and (accept && `in_last`).
  - A product is valid when `vpipe[LAT-1]` = 1.
- On a valid product:
  - acc <= acc + zero-extended `mul_p`; carry out of ACC_W sets sticky ovf.
  - count <= count + 1, saturating at all-ones; saturation sets ovf.
- Transitions:
  - ACCUM -> DRAIN on accept with `in_last`.
  - DRAIN -> HOLD when `lpipe[LAT-1]`. In that cycle `out_acc`/`out_count`/`out_ovf` register the final values, including the last product.
  - HOLD -> ACCUM when `out_ready`. acc, count and ovf clear to 0 on the same edge.
- In HOLD, `out_valid` = 1 and the outputs are stable until accepted.
- Wrapper has no reset. Its stale contents are ignored because `vpipe` resets to 0.
- Reset mid-operation: all state, pipes and outputs clear immediately. In-flight products are discarded and the next group starts clean.

## Timing
- Reset values:
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `out_acc`, `out_count`, `out_ovf` = 0.
  - `mul_a`, `mul_b` = 0.
- Throughput: one pair per cycle while in ACCUM.
- Accept in cycle t produces a valid `mul_p` in cycle t+LAT. acc updates at the end of t+LAT.
- Last beat accepted in cycle t: `out_valid` rises in cycle t+LAT+1 (t+3 at default).
- Bubbles (`in_valid` = 0) inside a group are legal and add nothing to the sum.
- `in_ready` is low from the cycle after the last accept until the cycle after `out_ready` is seen in HOLD.
- `out_ready` asserted before `out_valid` has no effect.
- The output is not dropped or duplicated under any `out_ready` pattern.

## Structure
- Package `mult32u_mac_pkg` holds:
  - the state enum (ACCUM/DRAIN/HOLD);
  - the default `ACC_W`, `LAT` and `CNT_W` constants.
- One sub-module: `mult32u_mac_pipe`, the LAT-deep valid/last shift register with async clear.
- The multiplier wrapper is instantiated beside this block, not inside it.

## Test plan
- Single-beat group: accept a=3, b=5, last=1 at cycle 0 -> `out_valid` at cycle 3, `out_acc` = 15, `out_count` = 1, `out_ovf` = 0.
- Four back-to-back beats (1x2, 3x4, 5x6, 7x8), last on beat 4 -> `out_acc` = 100, `out_count` = 4. `in_ready` is low from the cycle after beat 4.
- Max operands: 0xFFFFFFFF x 0xFFFFFFFF for 3 beats -> `out_acc` = 3 x 0xFFFFFFFE00000001 with no truncation, `out_ovf` = 0.
- Backpressure: hold `out_ready` = 0 for 10 cycles -> outputs stable, `in_ready` = 0. The next group's sum starts from 0 after release.
- Bubbles: beats 2x2, idle, idle, 3x3 (last) -> `out_acc` = 13, `out_count` = 2.
- Reset mid-operation: assert `rst_n` = 0 one cycle after a non-last accept -> all outputs reset at once. A subsequent 6x7 single-beat group gives `out_acc` = 42.

Source files
------------

// File: rtl/mult32u_mac_pkg.sv
// mult32u_mac_pkg
//   Shared definitions for the multiply-accumulate controller:
//   - default widths and multiplier latency
//   - state encoding of the group controller
package mult32u_mac_pkg;

  localparam int DEF_ACC_W = 80;  // accumulator / result width, >= 64
  localparam int DEF_LAT   = 2;   // wrapper latency: operands in -> product valid
  localparam int DEF_CNT_W = 16;  // beat counter width

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,  // accepting operand pairs of the current group
    ST_DRAIN = 2'd1,  // last pair issued, waiting for its product
    ST_HOLD  = 2'd2   // result presented until downstream takes it
  } mac_state_e;

endpackage

// File: rtl/mult32u_mac_ctrl_if.sv
// mult32u_mac_ctrl_if
//   Bundles the operand stream, the multiplier wrapper connection and the
//   result stream of mult32u_mac_ctrl.
//   Operand stream : in_valid, in_ready, in_last, in_a, in_b
//   Wrapper side   : mul_a, mul_b (to wrapper), mul_p (from wrapper)
//   Result stream  : out_valid, out_ready, out_acc, out_count, out_ovf
//   Modports: slave = the controller, master = its environment.
interface mult32u_mac_ctrl_if
  import mult32u_mac_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
);

  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [31:0]      mul_a;
  logic [31:0]      mul_b;
  logic [63:0]      mul_p;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_last, in_a, in_b, mul_p, out_ready,
    output in_ready, mul_a, mul_b, out_valid, out_acc, out_count, out_ovf
  );

  modport master (
    output in_valid, in_last, in_a, in_b, mul_p, out_ready,
    input  in_ready, mul_a, mul_b, out_valid, out_acc, out_count, out_ovf
  );

endinterface

// File: rtl/mult32u_mac_pipe.sv
// mult32u_mac_pipe
//   LAT-deep shift register that follows each issued operand pair through
//   the multiplier pipeline, so the controller knows which cycle's mul_p
//   is a real product and which one closes the group.
//   clk, rst_n : clock, asynchronous active-low clear
//   v_in, l_in : pair issued this cycle / that pair is the group's last
//   v_out      : mul_p carries a valid product this cycle
//   l_out      : that product is the group's last
module mult32u_mac_pipe #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic v_in,
  input  logic l_in,
  output logic v_out,
  output logic l_out
);

  logic [LAT-1:0] v_reg;
  logic [LAT-1:0] l_reg;
  logic [LAT-1:0] v_next;
  logic [LAT-1:0] l_next;

  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign v_next[gi] = v_in;
        assign l_next[gi] = l_in;
      end else begin : g_tail
        assign v_next[gi] = v_reg[gi-1];
        assign l_next[gi] = l_reg[gi-1];
      end
    end
  endgenerate

  // Clearing on reset is what makes the unreset wrapper's stale
  // pipeline contents harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_reg <= '0;
      l_reg <= '0;
    end else begin
      v_reg <= v_next;
      l_reg <= l_next;
    end
  end

  assign v_out = v_reg[LAT-1];
  assign l_out = l_reg[LAT-1];

endmodule

// File: rtl/mult32u_mac_ctrl.sv
// mult32u_mac_ctrl
//   Issues operand pairs to an external registered 32x32 multiplier,
//   sums the returning products per group (delimited by in_last) and
//   presents one dot-product result per group.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : operand stream, wrapper operands/product, result stream
module mult32u_mac_ctrl
  import mult32u_mac_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int LAT   = DEF_LAT,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  mult32u_mac_ctrl_if.slave   bus
);

  mac_state_e       state_reg, state_next;
  logic             in_ready;
  logic             out_valid;
  logic             accept;
  logic             prod_valid;
  logic             prod_last;

  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             ovf_reg, ovf_next;
  logic [ACC_W:0]   sum_ext;

  logic [ACC_W-1:0] out_acc_reg;
  logic [CNT_W-1:0] out_cnt_reg;
  logic             out_ovf_reg;

  assign accept = bus.in_valid && in_ready;

  // Operands are zero unless a pair is actually issued, so the
  // multiplier array does not toggle on idle cycles.
  assign bus.mul_a = accept ? bus.in_a : '0;
  assign bus.mul_b = accept ? bus.in_b : '0;

  mult32u_mac_pipe #(.LAT(LAT)) u_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .v_in  (accept),
    .l_in  (accept && bus.in_last),
    .v_out (prod_valid),
    .l_out (prod_last)
  );

  // ---------------- state machine ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_ACCUM;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (bus.in_valid && bus.in_last) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (prod_last) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_next = ST_ACCUM;
      end
      default: state_next = ST_ACCUM;
    endcase
  end

  // ---------------- accumulate ----------------
  // One extra bit on the sum exposes the carry out of the accumulator.
  assign sum_ext = {1'b0, acc_reg} + (ACC_W+1)'(bus.mul_p);

  always_comb begin
    acc_next = acc_reg;
    cnt_next = cnt_reg;
    ovf_next = ovf_reg;
    if (prod_valid) begin
      acc_next = sum_ext[ACC_W-1:0];
      if (sum_ext[ACC_W]) ovf_next = 1'b1;
      if (&cnt_reg) ovf_next = 1'b1;
      else          cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg     <= '0;
      cnt_reg     <= '0;
      ovf_reg     <= 1'b0;
      out_acc_reg <= '0;
      out_cnt_reg <= '0;
      out_ovf_reg <= 1'b0;
    end else begin
      if (state_reg == ST_HOLD && bus.out_ready) begin
        acc_reg <= '0;
        cnt_reg <= '0;
        ovf_reg <= 1'b0;
      end else begin
        acc_reg <= acc_next;
        cnt_reg <= cnt_next;
        ovf_reg <= ovf_next;
      end
      // Capture uses the *_next values so the group's final product,
      // arriving in this very cycle, is included.
      if (state_reg == ST_DRAIN && prod_last) begin
        out_acc_reg <= acc_next;
        out_cnt_reg <= cnt_next;
        out_ovf_reg <= ovf_next;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_acc   = out_acc_reg;
  assign bus.out_count = out_cnt_reg;
  assign bus.out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_mult32u_mac_ctrl.sv
// tb_mult32u_mac_ctrl
//   Scoreboard bench: each group pushes its hand-computed result into a
//   queue; a monitor pops and compares on every result handshake.
//   A two-stage registered multiplier model stands in for the wrapper.
module tb_mult32u_mac_ctrl;
  import mult32u_mac_pkg::*;

  localparam int ACC_W = DEF_ACC_W;
  localparam int CNT_W = DEF_CNT_W;

  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  mult32u_mac_ctrl_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  mult32u_mac_ctrl #(.ACC_W(ACC_W), .LAT(DEF_LAT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Wrapper model: registered, no reset, product two cycles after operands.
  logic [63:0] p1, p2;
  always @(posedge clk) begin
    p1 <= 64'(bus.mul_a) * 64'(bus.mul_b);
    p2 <= p1;
  end
  assign bus.mul_p = p2;

  task automatic check(input string name, input logic [ACC_W-1:0] got,
                       input logic [ACC_W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end else begin
      $display("ok   %s: %0h", name, got);
    end
  endtask

  // Monitor: one comparison set per accepted result.
  always @(negedge clk) begin
    #1;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("result acc=%0h count=%0d ovf=%0b", bus.out_acc, bus.out_count, bus.out_ovf);
        check("out_acc", bus.out_acc, e.acc);
        check("out_count", ACC_W'(bus.out_count), ACC_W'(e.cnt));
        check("out_ovf", ACC_W'(bus.out_ovf), ACC_W'(e.ovf));
      end
    end
  end

  task automatic push_exp(input logic [ACC_W-1:0] acc, input int cnt);
    exp_t e;
    e.acc = acc;
    e.cnt = CNT_W'(cnt);
    e.ovf = 1'b0;
    exp_q.push_back(e);
  endtask

  // Drive one pair and return right after the edge that accepted it.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last);
    int guard;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_last = last;
    guard = 0;
    #1;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 50) check("in_ready_timeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk);
    end
  endtask

  // Waits (bounded) for out_valid; returns cycles counted from the
  // accept edge (1 = first cycle after it).
  task automatic wait_out(output int n);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      n++;
      if (bus.out_valid) return;
    end
    check("out_valid_timeout", 0, 1);
  endtask

  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", ACC_W'(bus.in_ready), 1);
    check("rst_out_valid", ACC_W'(bus.out_valid), 0);
    check("rst_out_acc", bus.out_acc, 0);
    check("rst_out_count", ACC_W'(bus.out_count), 0);
    check("rst_out_ovf", ACC_W'(bus.out_ovf), 0);
    check("rst_mul_a", ACC_W'(bus.mul_a), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single beat 3x5, latency 3
    push_exp(15, 1);
    send(3, 5, 1);
    wait_out(n);
    check("single_latency", ACC_W'(n), 3);

    // Four back-to-back beats
    push_exp(100, 4);
    send(1, 2, 0);
    send(3, 4, 0);
    send(5, 6, 0);
    send(7, 8, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("in_ready_after_last", ACC_W'(bus.in_ready), 0);
    wait_out(n);

    // Max operands, three beats, no truncation
    push_exp(80'h2_FFFF_FFFA_0000_0003, 3);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    wait_out(n);

    // Backpressure: 10 cycles held, then next group starts from 0
    @(negedge clk);
    bus.out_ready = 1'b0;
    push_exp(81, 1);
    send(9, 9, 1);
    wait_out(n);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("bp_out_valid", ACC_W'(bus.out_valid), 1);
      check("bp_out_acc", bus.out_acc, 81);
      check("bp_in_ready", ACC_W'(bus.in_ready), 0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    push_exp(20, 1);
    send(4, 5, 1);
    wait_out(n);

    // Bubbles inside a group
    push_exp(13, 2);
    send(2, 2, 0);
    idle(2);
    send(3, 3, 1);
    wait_out(n);

    // Reset one cycle after a non-last accept
    send(10, 10, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", ACC_W'(bus.out_valid), 0);
    check("mid_rst_in_ready", ACC_W'(bus.in_ready), 1);
    check("mid_rst_out_acc", bus.out_acc, 0);
    check("mid_rst_out_count", ACC_W'(bus.out_count), 0);
    check("mid_rst_out_ovf", ACC_W'(bus.out_ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(42, 1);
    send(6, 7, 1);
    wait_out(n);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", ACC_W'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
